gray_code_decoder_tracker: RTL and testbench

Receive-side companion to the 4-bit Gray code counter: samples a 4-bit reflected Gray code bus, decodes it to binary, and classifies every change as a legal +1 step, a legal −1 step, or a fault. A signed-wrap position accumulator counts net steps. The block sits at the consuming end of any Gray-coded count bus, such as a counter in another clock domain or a rotary encoder, and feeds binary value, step pulses and fault status to downstream logic.

---
 rtl/gray_code_decoder_tracker.sv | 172 +++++++++++++++++
 tb/tb_gray_code_decoder_tracker.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/gray_code_decoder_tracker.sv
// rtl/gray_code_decoder_tracker.sv - Gray code bus decoder with step classification, fault tracking and position count
// Optional feature macro: GRAY_DEC_SYNC_EN (two-flop input synchronizer on datain)

module gray_code_decoder_tracker #(
  parameter int POS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           datain,
  input  logic                 clear_err,
  output logic [3:0]           dataout,
  output logic                 valid,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 error,
  output logic [POS_WIDTH-1:0] position
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [POS_WIDTH-1:0] POS_ONE = {{(POS_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q;
  state_t               state_d;
  logic [3:0]           sample;
  logic [3:0]           sample_bin;
  logic [3:0]           last_gray;
  logic                 is_hold;
  logic                 is_up;
  logic                 is_down;

  logic [3:0]           last_gray_d;
  logic [3:0]           dataout_d;
  logic                 valid_d;
  logic                 step_up_d;
  logic                 step_down_d;
  logic                 error_d;
  logic [POS_WIDTH-1:0] position_d;

  // Reflected Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    b[2] = b[3] ^ g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

`ifdef GRAY_DEC_SYNC_EN
  logic [3:0] sync_q1;
  logic [3:0] sync_q2;

  // Two-flop synchronizer so datain may come from another clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1 <= 4'd0;
      sync_q2 <= 4'd0;
    end else begin
      sync_q1 <= datain;
      sync_q2 <= sync_q1;
    end
  end

  assign sample = sync_q2;
`else
  assign sample = datain;
`endif

  assign sample_bin = gray2bin(sample);
  assign is_hold    = (sample == last_gray);
  assign is_up      = (sample_bin == dataout + 4'd1);
  assign is_down    = (sample_bin == dataout - 4'd1);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear_err overrides everything and re-arms through INIT
  always_comb begin
    state_d = state_q;
    if (clear_err) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_INIT:  state_d = ST_TRACK;
        ST_TRACK: begin
          if (!is_hold && !is_up && !is_down) begin
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_INIT;
      endcase
    end
  end

  // Next values of the registered outputs; pulses default low every cycle
  always_comb begin
    last_gray_d = last_gray;
    dataout_d   = dataout;
    valid_d     = valid;
    step_up_d   = 1'b0;
    step_down_d = 1'b0;
    error_d     = error;
    position_d  = position;
    if (clear_err) begin
      error_d = 1'b0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          last_gray_d = sample;
          dataout_d   = sample_bin;
          valid_d     = 1'b1;
        end
        ST_TRACK: begin
          if (is_hold) begin
            // no change on the bus
          end else if (is_up) begin
            last_gray_d = sample;
            dataout_d   = sample_bin;
            step_up_d   = 1'b1;
            position_d  = position + POS_ONE;
          end else if (is_down) begin
            last_gray_d = sample;
            dataout_d   = sample_bin;
            step_down_d = 1'b1;
            position_d  = position - POS_ONE;
          end else begin
            error_d = 1'b1;
            valid_d = 1'b0;
          end
        end
        default: begin
          // FAULT: everything frozen until clear_err
        end
      endcase
    end
  end

  // Output and tracking registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_gray <= 4'd0;
      dataout   <= 4'd0;
      valid     <= 1'b0;
      step_up   <= 1'b0;
      step_down <= 1'b0;
      error     <= 1'b0;
      position  <= '0;
    end else begin
      last_gray <= last_gray_d;
      dataout   <= dataout_d;
      valid     <= valid_d;
      step_up   <= step_up_d;
      step_down <= step_down_d;
      error     <= error_d;
      position  <= position_d;
    end
  end

endmodule

// File: tb/tb_gray_code_decoder_tracker.sv
// tb/tb_gray_code_decoder_tracker.sv - directed scoreboard bench for gray_code_decoder_tracker

module tb_gray_code_decoder_tracker;

  typedef struct packed {
    logic [3:0] dataout;
    logic       valid;
    logic       step_up;
    logic       step_down;
    logic       error;
    logic [7:0] position;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] datain = 4'd0;
  logic       clear_err = 1'b0;
  logic [3:0] dataout;
  logic       valid;
  logic       step_up;
  logic       step_down;
  logic       error;
  logic [7:0] position;

  obs_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  gray_code_decoder_tracker #(.POS_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .datain    (datain),
    .clear_err (clear_err),
    .dataout   (dataout),
    .valid     (valid),
    .step_up   (step_up),
    .step_down (step_down),
    .error     (error),
    .position  (position)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input logic [3:0] d, input logic v, input logic u,
                              input logic dn, input logic e, input logic [7:0] p);
    obs_t o;
    o.dataout = d; o.valid = v; o.step_up = u; o.step_down = dn; o.error = e; o.position = p;
    return o;
  endfunction

  task automatic check_now(input string tag);
    obs_t o;
    obs_t e;
    o = {dataout, valid, step_up, step_down, error, position};
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, o);
    end else begin
      e = exp_q.pop_front();
      assert (o === e) passed++;
      else $error("FAIL %s observed d=%h v=%b u=%b dn=%b e=%b p=%h expected d=%h v=%b u=%b dn=%b e=%b p=%h",
                  tag, o.dataout, o.valid, o.step_up, o.step_down, o.error, o.position,
                  e.dataout, e.valid, e.step_up, e.step_down, e.error, e.position);
    end
  endtask

  // Drive inputs, queue the expected post-edge outputs, compare just after the edge
  task automatic drive(input string tag, input logic [3:0] g, input logic clr, input obs_t e);
    datain = g;
    clear_err = clr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    check_now(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    datain = 4'd0;
    clear_err = 1'b0;
    #2;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    check_now("reset_async");
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] pos;
    logic [3:0] v;
    logic [3:0] g;

    // Reset held from time zero, checked before any clock edge
    #2;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    check_now("reset_state");
    @(negedge clk);
    reset = 1'b1;
    drive("init_capture", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

    // Full walk up, one code per 4 cycles, ending with the 15 -> 0 wrap
    pos = 8'h00;
    for (int k = 1; k <= 16; k++) begin
      v = 4'(k);
      g = v ^ (v >> 1);
      pos = pos + 8'h01;
      drive("walk_up_step", g, 1'b0, mk(v, 1'b1, 1'b1, 1'b0, 1'b0, pos));
      for (int h = 0; h < 3; h++)
        drive("walk_up_hold", g, 1'b0, mk(v, 1'b1, 1'b0, 1'b0, 1'b0, pos));
    end
    drive("walk_up_final", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h10));

    // Down steps from zero: position wraps to all-ones, then back up through the wrap
    do_reset();
    drive("init2", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    drive("down_0_to_15", 4'b1000, 1'b0, mk(4'd15, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF));
    drive("down_15_to_14", 4'b1001, 1'b0, mk(4'd14, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE));
    drive("down_hold", 4'b1001, 1'b0, mk(4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE));
    drive("up_14_to_15", 4'b1000, 1'b0, mk(4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF));
    drive("up_15_to_0", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00));

    // Two-bit change -> fault, then clear and re-arm on the faulty code
    drive("multibit_fault", 4'b0011, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    drive("fault_hold", 4'b0011, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
    drive("clear_err", 4'b0011, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    drive("rearm_init", 4'b0011, 1'b0, mk(4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    drive("down_2_to_1", 4'b0001, 1'b0, mk(4'd1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF));
    drive("down_1_to_0", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFE));

    // Single-bit but non-adjacent change -> fault; returning to the old code stays faulted
    drive("nonadj_fault", 4'b0010, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE));
    drive("fault_sticky", 4'b0000, 1'b0, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFE));
    drive("clear_err2", 4'b0000, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE));
    drive("rearm_init2", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE));

    // clear_err wins over a simultaneous legal step
    drive("clear_prio", 4'b0001, 1'b1, mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFE));
    drive("clear_prio_init", 4'b0001, 1'b0, mk(4'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFE));

    // Walk to position 5, then assert reset between edges
    do_reset();
    drive("init3", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));
    for (int k = 1; k <= 5; k++) begin
      v = 4'(k);
      g = v ^ (v >> 1);
      drive("walk_to_5", g, 1'b0, mk(v, 1'b1, 1'b1, 1'b0, 1'b0, 8'(k)));
    end
    #2;
    reset = 1'b0;
    #1;
    exp_q.push_back(mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    check_now("midop_async_reset");
    @(negedge clk);
    reset = 1'b1;
    drive("post_reset_init", 4'b0000, 1'b0, mk(4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
